// File: rtl/arb4_rr_dec_if.sv
// Request/grant bundle between the requesters and the arb4_rr_dec round-robin arbiter.
interface arb4_rr_dec_if;
    logic [3:0] req;
    logic [1:0] gnt_idx;
    logic [3:0] gnt_n;
    logic       en_n;
    logic       tout;

    modport master (output req, input gnt_idx, gnt_n, en_n, tout);
    modport slave  (input req, output gnt_idx, gnt_n, en_n, tout);
endinterface

// File: rtl/arb4_rr_dec.sv
// Four-requester round-robin arbiter driving active-low 1-of-4 selects with a one-cycle gap.
// Define ARB4_TIMEOUT_EN to build the hold counter that force-releases a grant after HOLD_MAX cycles.
module arb4_rr_dec #(
    parameter int unsigned HOLD_MAX = 16
) (
    input logic          clk,
    input logic          rst,
    arb4_rr_dec_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    if (HOLD_MAX < 2 || HOLD_MAX > 256) begin : g_bad_hold
        $error("arb4_rr_dec: HOLD_MAX must be within 2..256");
    end

    state_t     state, state_nx;
    logic [1:0] last_idx, last_nx;
    logic [1:0] idx_q, idx_nx;
    logic [3:0] gnt_q, gnt_nx;
    logic       en_q, en_nx;
    logic       tout_q, tout_nx;
    logic [1:0] winner, cand;
    logic       found;
    logic       expire;

    // Scan starts just past the last winner, so that winner ends up with lowest priority.
    always_comb begin
        winner = last_idx;
        found  = 1'b0;
        cand   = last_idx;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = last_idx + 2'(k);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

`ifdef ARB4_TIMEOUT_EN
    localparam int unsigned CW = $clog2(HOLD_MAX);
    logic [CW-1:0] cnt_q;

    assign expire = (cnt_q == CW'(HOLD_MAX - 1));

    // Held at zero outside GRANT, so every fresh grant starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state == GRANT) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        last_nx  = last_idx;
        idx_nx   = idx_q;
        gnt_nx   = gnt_q;
        en_nx    = en_q;
        tout_nx  = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (found) begin
                    state_nx = GRANT;
                    idx_nx   = winner;
                    gnt_nx   = ~(4'b0001 << winner);
                    en_nx    = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            GRANT: begin
                // A release wins over a coincident timeout, leaving tout low.
                if (!bus.req[idx_q] || expire) begin
                    state_nx = GAP;
                    gnt_nx   = '1;
                    en_nx    = 1'b1;
                    last_nx  = idx_q;
                    tout_nx  = bus.req[idx_q];
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '1;
                en_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_idx <= 2'b11;
            idx_q    <= '0;
            gnt_q    <= '1;
            en_q     <= 1'b1;
            tout_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            last_idx <= last_nx;
            idx_q    <= idx_nx;
            gnt_q    <= gnt_nx;
            en_q     <= en_nx;
            tout_q   <= tout_nx;
        end
    end

    assign bus.gnt_idx = idx_q;
    assign bus.gnt_n   = gnt_q;
    assign bus.en_n    = en_q;
    assign bus.tout    = tout_q;
endmodule
